seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexing scan controller that shares one BCD-to-7-segment decoder among NDIG common-anode/cathode digit positions of the board display. It accepts a full BCD word through a load/ready handshake and applies it only at frame boundaries, so the display never tears. It steps a one-hot digit enable at a prescaled rate, feeds the selected nibble to the external decoder, and gates the decoded pattern with blanking and decimal-point control. It sits between the counter/datapath that produces BCD values and the display pins.

## Interface
- NDIG, 4, number of digit positions (2..8)
- SCAN_DIV, 50000, clock cycles each digit stays lit (≥2)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  1 = scan runs; 0 = prescaler/index frozen, all digits off
- load  in  1  request to capture value/dp_mask/lz_en
- value  in  4*NDIG  BCD word; nibble i drives digit i, digit 0 = least significant
- dp_mask  in  NDIG  bit i lights the decimal point of digit i
- lz_en  in  1  1 = leading-zero suppression
- ready  out  1  1 = load will be accepted this cycle
- dec_in  out  4  nibble presented to the decoder
- seg_in  in  8  decoder output, bit7..bit1 = segments a..g, bit0 = dp, 1 = lit
- seg_out  out  8  pattern driven to display segments, same format
- an  out  NDIG  one-hot digit enable, 1 = digit lit

## Operation
- Registers: prescaler cnt (0..SCAN_DIV-1), digit index idx (0..NDIG-1), shadow set {value, dp_mask, lz_en}, active set, pending flag.
- Reset values: cnt=0, idx=0, shadow=0, active=0 (value 0, dp 0, lz 0), pending=0, ready=1, an=one-hot digit 0 (1), dec_in=0, blank_r=0, dp_r=0; seg_out therefore = {seg_in[7:1],0}.
- Scan: when en=1, cnt increments each cycle; at cnt=SCAN_DIV-1 a tick occurs, cnt→0, idx→idx+1, wrapping NDIG-1→0. Frame boundary = tick with idx=NDIG-1.
- Handshake: load sampled only when ready=1 → shadow captures inputs, pending=1, ready=0. load while ready=0 is ignored; shadow is not overwritten.
- Apply: at a frame boundary with pending=1 (pending set on a prior cycle), active←shadow, pending=0, ready=1 on next cycle. load on the same cycle as a frame boundary while ready=1 is captured and applied at the following frame boundary.
- Per-digit outputs (registered from idx and active set): an=1<<idx; dec_in=active nibble idx, or 0 when blank; dp_r=active dp_mask[idx].
- Blank when: nibble >9 (invalid BCD; dec_in forced 0), or lz_en=1 and idx>0 and nibble idx and every higher nibble are 0. Digit 0 is never LZ-blanked.
- seg_out (combinational): blank_r ? 8'h00 : {seg_in[7:1], dp_r}; decoder's own bit0 is discarded. Invalid-BCD digits also have dp suppressed.
- en=0: cnt and idx hold, an=0, seg_out=0; handshake still accepts load, but apply waits for a real frame boundary. en 0→1 resumes from held cnt/idx.

## Timing
- Index change at tick edge T; an, dec_in, blank_r, dp_r update at edge T+1 (1-cycle latency). seg_out valid same cycle as dec_in, given combinational decoder.
- Each digit lit exactly SCAN_DIV cycles; frame period NDIG*SCAN_DIV cycles.
- Load-to-display latency: from accepting edge to next frame boundary plus 1 cycle; worst case NDIG*SCAN_DIV+1.
- ready low for ≥1 cycle after any accepted load.
- rst asserted mid-frame: all registers return to reset values immediately; any pending update is discarded; scan restarts at digit 0, cnt=0 after release.

## Test plan
- Reset: assert rst mid-scan with NDIG=4, SCAN_DIV=4 → an=4'b0001, dec_in=0, ready=1, seg_out={seg_in[7:1],0} while rst high and first cycle after.
- Scan order: en=1, SCAN_DIV=4 → an sequences 0001,0010,0100,1000,0001, each held exactly 4 cycles; frame = 16 cycles.
- Handshake: load value=16'h1234 mid-frame → ready=0 next cycle; second load 16'h9999 while ready=0 ignored; at frame boundary +1 dec_in shows 4,3,2,1 on digits 0..3, ready=1.
- Leading zeros: value=16'h0075, lz_en=1 → digits 3,2 seg_out=0, digits 1,0 dec_in=7,5; lz_en=0 → digits 3,2 dec_in=0 and lit; value=0 with lz_en=1 → only digit 0 lit showing 0.
- Invalid/dp: value=16'h00A3, dp_mask=4'b0011 → digit 1 blank with dp off (dec_in=0), digit 0 shows 3 with seg_out[0]=1.
- en=0 mid-digit 2 for 10 cycles → an=0, seg_out=0, idx/cnt held; on en=1 digit 2 completes remaining cycles only.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an NDIG-digit 7-segment
// display sharing one external BCD-to-7-segment decoder.
//
// A BCD word (plus decimal-point mask and leading-zero enable) is captured
// through a load/ready handshake into a shadow set and copied to the active
// set only at a frame boundary, so a frame never shows a mix of old and new
// digits.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   en       1 = scan runs; 0 = scan frozen and all digits dark
//   load     capture request for value/dp_mask/lz_en (taken when ready=1)
//   value    BCD word, nibble i drives digit i (digit 0 = least significant)
//   dp_mask  bit i lights the decimal point of digit i
//   lz_en    1 = leading-zero suppression
//   ready    1 = a load this cycle is accepted
//   dec_in   nibble presented to the external decoder
//   seg_in   decoder output {a,b,c,d,e,f,g,dp}, 1 = lit
//   seg_out  gated segment pattern to the display
//   an       one-hot digit enable, 1 = lit
module seg_scan_ctrl #(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [4*NDIG-1:0] value,
  input  logic [NDIG-1:0]   dp_mask,
  input  logic              lz_en,
  output logic              ready,
  output logic [3:0]        dec_in,
  input  logic [7:0]        seg_in,
  output logic [7:0]        seg_out,
  output logic [NDIG-1:0]   an
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NDIG);

  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic              pending;
  logic [4*NDIG-1:0] sh_value;
  logic [NDIG-1:0]   sh_dp;
  logic              sh_lz;
  logic [4*NDIG-1:0] act_value;
  logic [NDIG-1:0]   act_dp;
  logic              act_lz;
  logic              blank_r;
  logic              dp_r;

  logic              tick;
  logic              frame_end;
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              upper_zero;
  logic              digit_blank;
  logic [NDIG-1:0]   an_next;

  // The decoder's own dp output is replaced by dp_mask.
  logic              seg_dp_unused;
  assign seg_dp_unused = seg_in[0];

  assign ready     = ~pending;
  assign tick      = en && (cnt == CW'(SCAN_DIV - 1));
  assign frame_end = tick && (idx == IW'(NDIG - 1));

  // Select the current digit and decide whether it is blanked. A digit is
  // leading-zero blanked when it and every more significant digit are zero;
  // digit 0 always shows so a zero value still displays "0".
  always_comb begin
    cur_nib    = 4'd0;
    cur_dp     = 1'b0;
    upper_zero = 1'b1;
    an_next    = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (IW'(i) == idx) begin
        cur_nib    = act_value[4*i +: 4];
        cur_dp     = act_dp[i];
        an_next[i] = en;
      end
      if ((IW'(i) >= idx) && (act_value[4*i +: 4] != 4'd0)) begin
        upper_zero = 1'b0;
      end
    end
    digit_blank = (cur_nib > 4'd9) || (act_lz && (idx != '0) && upper_zero);
  end

  // Scan counter and digit index; both freeze while en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (en) begin
      if (tick) begin
        cnt <= '0;
        idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Handshake: a load is only taken while nothing is pending; the pending
  // set moves to the active set at the next real frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= 1'b0;
      sh_value  <= '0;
      sh_dp     <= '0;
      sh_lz     <= 1'b0;
      act_value <= '0;
      act_dp    <= '0;
      act_lz    <= 1'b0;
    end else if (pending) begin
      if (frame_end) begin
        act_value <= sh_value;
        act_dp    <= sh_dp;
        act_lz    <= sh_lz;
        pending   <= 1'b0;
      end
    end else if (load) begin
      sh_value <= value;
      sh_dp    <= dp_mask;
      sh_lz    <= lz_en;
      pending  <= 1'b1;
    end
  end

  // Per-digit outputs, one cycle behind idx.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an      <= {{(NDIG-1){1'b0}}, 1'b1};
      dec_in  <= 4'd0;
      blank_r <= 1'b0;
      dp_r    <= 1'b0;
    end else begin
      an      <= an_next;
      dec_in  <= digit_blank ? 4'd0 : cur_nib;
      blank_r <= ~en | digit_blank;
      dp_r    <= cur_dp;
    end
  end

  assign seg_out = blank_r ? 8'h00 : {seg_in[7:1], dp_r};

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;
  localparam int NDIG = 4;
  localparam int SD   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_mask = '0;
  logic        lz_en = 1'b0;
  logic        ready;
  logic [3:0]  dec_in;
  logic [7:0]  seg_in = 8'hB7;
  logic [7:0]  seg_out;
  logic [3:0]  an;

  int n_chk  = 0;
  int n_fail = 0;
  bit sb_on  = 1'b0;

  seg_scan_ctrl #(.NDIG(NDIG), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .value(value),
    .dp_mask(dp_mask), .lz_en(lz_en), .ready(ready), .dec_in(dec_in),
    .seg_in(seg_in), .seg_out(seg_out), .an(an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: scan position, handshake and display contents.
  int          m_cnt, m_idx;
  bit          m_pend;
  logic [15:0] sh_val, act_val;
  logic [3:0]  sh_dp, act_dp;
  bit          sh_lz, act_lz;
  int          e_an, e_dec;
  bit          e_blank, e_dp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_idx = 0; m_pend = 0;
      sh_val = 0; sh_dp = 0; sh_lz = 0;
      act_val = 0; act_dp = 0; act_lz = 0;
      e_an = 1; e_dec = 0; e_blank = 0; e_dp = 0;
    end else begin
      int  nib;
      bit  inv, lzb, tick;
      nib     = int'((act_val >> (4*m_idx)) & 16'hF);
      inv     = nib > 9;
      lzb     = act_lz && m_idx > 0 && ((act_val >> (4*m_idx)) == 0);
      e_an    = en ? (1 << m_idx) : 0;
      e_blank = !en || inv || lzb;
      e_dec   = (inv || lzb) ? 0 : nib;
      e_dp    = act_dp[m_idx];
      tick    = en && (m_cnt == SD - 1);
      if (m_pend) begin
        if (tick && m_idx == NDIG - 1) begin
          act_val = sh_val; act_dp = sh_dp; act_lz = sh_lz; m_pend = 0;
        end
      end else if (load) begin
        sh_val = value; sh_dp = dp_mask; sh_lz = lz_en; m_pend = 1;
      end
      if (en) begin
        if (tick) begin
          m_cnt = 0;
          m_idx = (m_idx + 1) % NDIG;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (sb_on) begin
      chk("sb_an", an, e_an);
      chk("sb_dec", dec_in, e_dec);
      chk("sb_ready", ready, !m_pend);
      chk("sb_seg", seg_out, e_blank ? 8'h00 : {seg_in[7:1], e_dp});
    end
  end

  task automatic wait_an(input logic [3:0] t, input string nm);
    int n = 0;
    @(negedge clk);
    while (an !== t && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_reach"}, an, t);
  endtask

  task automatic show(input int d, input logic [3:0] ed, input logic [7:0] es, input string nm);
    wait_an(4'(1 << d), nm);
    chk({nm, "_dec"}, dec_in, ed);
    chk({nm, "_seg"}, seg_out, es);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic lz);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("load_ready", ready, 1);
    value = v; dp_mask = dp; lz_en = lz; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    repeat (18) @(posedge clk);
  endtask

  initial begin
    logic [3:0] exp_digits [4];
    #1 rst = 1'b1;
    en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_an", an, 4'b0001);
    chk("rst_dec", dec_in, 0);
    chk("rst_ready", ready, 1);
    chk("rst_seg", seg_out, 8'hB6);
    sb_on = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    // scan order: each digit held SD cycles, wrapping after NDIG digits
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("scan_an", an, 1 << (((k - 1) / SD) % NDIG));
    end

    // handshake: second load while ready is low must be ignored
    @(posedge clk);
    #1 value = 16'h1234; dp_mask = 0; lz_en = 0; load = 1'b1;
    @(posedge clk);
    #1 value = 16'h9999;
    @(negedge clk);
    chk("hs_ready_low", ready, 0);
    @(posedge clk);
    #1 load = 1'b0;
    repeat (18) @(posedge clk);
    exp_digits = '{4'd4, 4'd3, 4'd2, 4'd1};
    for (int d = 0; d < 4; d++) show(d, exp_digits[d], 8'hB6, "hs_digit");
    chk("hs_ready_high", ready, 1);

    // leading-zero suppression
    do_load(16'h0075, 4'b0000, 1'b1);
    show(3, 0, 8'h00, "lz_d3");
    show(2, 0, 8'h00, "lz_d2");
    show(1, 7, 8'hB6, "lz_d1");
    show(0, 5, 8'hB6, "lz_d0");
    do_load(16'h0075, 4'b0000, 1'b0);
    show(3, 0, 8'hB6, "nolz_d3");
    show(2, 0, 8'hB6, "nolz_d2");
    do_load(16'h0000, 4'b0000, 1'b1);
    show(1, 0, 8'h00, "zero_d1");
    show(0, 0, 8'hB6, "zero_d0");

    // invalid BCD blanks digit including dp; valid digit keeps dp
    do_load(16'h00A3, 4'b0011, 1'b0);
    show(1, 0, 8'h00, "inv_d1");
    show(0, 3, 8'hB7, "dp_d0");

    // en low mid digit 2: dark, position held, digit 2 finishes afterwards
    wait_an(4'b0100, "hold_start");
    @(posedge clk);
    #1 en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_an", an, 0);
      chk("hold_seg", seg_out, 0);
    end
    en = 1'b1;
    @(negedge clk); chk("resume_an1", an, 4'b0100);
    @(negedge clk); chk("resume_an2", an, 4'b0100);
    @(negedge clk); chk("resume_an3", an, 4'b1000);

    // reset mid-scan with an update pending
    @(posedge clk);
    #1 value = 16'h5678; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mrst_an", an, 4'b0001);
    chk("mrst_ready", ready, 1);
    chk("mrst_dec", dec_in, 0);
    chk("mrst_seg", seg_out, 8'hB6);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_after_an", an, 4'b0001);
    chk("mrst_after_seg", seg_out, 8'hB6);
    repeat (20) @(posedge clk);
    show(3, 0, 8'hB6, "mrst_discard");

    // randomized phase against the model
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      rst    = ($urandom_range(0, 499) == 0);
      en     = ($urandom_range(0, 9) != 0);
      load   = ($urandom_range(0, 4) == 0);
      seg_in = 8'($urandom);
      dp_mask = 4'($urandom);
      lz_en  = 1'($urandom);
      for (int d = 0; d < 4; d++) begin
        int r;
        r = $urandom_range(0, 15);
        value[4*d +: 4] = (r < 6) ? 4'd0 :
                          (r < 14) ? 4'($urandom_range(1, 9)) : 4'($urandom_range(10, 15));
      end
    end
    @(posedge clk);
    #1 rst = 1'b0; load = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
